// File: rtl/dlart_pkg.sv
// Shared constants for the DLART console FIFO: host register map and bit positions
// within the STATUS and CTRL registers.
package dlart_pkg;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_DATA   = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int ST_TXNE    = 0;
    localparam int ST_RXNF    = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_CNT_LSB = 3;

    localparam int CT_FLUSH   = 0;
    localparam int CT_CLROVR  = 1;

    localparam int DATA_W     = 8;

endpackage

// File: rtl/dlart_console_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO with one extra pointer bit for full/empty.
// Flush has priority over push and pop; head reads 0 while empty.
module sync_fifo
    import dlart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = DATA_W
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2:0]   rdPtr_q, rdPtr_d;
    logic                  empty;
    logic                  popOk;
    logic                  pushOk;

    assign empty  = (wrPtr_q == rdPtr_q);
    assign full_o = (wrPtr_q[DEPTH_LOG2] != rdPtr_q[DEPTH_LOG2]) &&
                    (wrPtr_q[DEPTH_LOG2-1:0] == rdPtr_q[DEPTH_LOG2-1:0]);
    assign popOk  = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pushOk = push_i && (!full_o || popOk);

    assign count_o = wrPtr_q - rdPtr_q;
    assign head_o  = empty ? '0 : mem_q[rdPtr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
            if (popOk)  rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk && !flush_i) mem_q[wrPtr_q[DEPTH_LOG2-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/dlart_console_fifo.sv
// Console byte buffer between the DLART bus emulation and the Apple II slot window.
// Optional sticky overrun flag enabled by defining DLART_OVERRUN_EN.
module dlart_console_fifo
    import dlart_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        odt_tx_stb,
    input  logic [7:0]  odt_tx_data,
    output logic        odt_tx_rdy,
    input  logic        odt_rx_stb,
    output logic [7:0]  odt_rx_data,
    output logic        odt_rx_rdy,
    input  logic [1:0]  host_addr,
    input  logic        host_rd,
    input  logic        host_wr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        irq
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] txSync_q, rxSync_q;
    logic                   txPrev_q, rxPrev_q;
    logic [SETTLE_W-1:0]    settle_q;
    logic                   armed, txEdge, rxEdge;

    logic                   txPopReq, rxPushReq, ctrlWr, flush;
    logic [7:0]             txHead, rxHead;
    logic                   txFull, rxFull, txNotEmpty, rxNotEmpty;
    logic [DEPTH_LOG2:0]    txCount, rxCount;
    logic                   ovr;
    logic [7:0]             status;

    // Edges are masked until the synchroniser has refilled after reset, so a strobe
    // that was already high when reset released never looks like a fresh edge.
    assign armed  = (settle_q == SETTLE_DONE);
    assign txEdge = armed && txSync_q[SYNC_STAGES-1] && !txPrev_q;
    assign rxEdge = armed && rxSync_q[SYNC_STAGES-1] && !rxPrev_q;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            txSync_q <= '0;
            rxSync_q <= '0;
            txPrev_q <= 1'b0;
            rxPrev_q <= 1'b0;
            settle_q <= '0;
        end else begin
            txSync_q <= {txSync_q[SYNC_STAGES-2:0], odt_tx_stb};
            rxSync_q <= {rxSync_q[SYNC_STAGES-2:0], odt_rx_stb};
            txPrev_q <= txSync_q[SYNC_STAGES-1];
            rxPrev_q <= rxSync_q[SYNC_STAGES-1];
            if (!armed) settle_q <= settle_q + 1'b1;
        end
    end

    assign txPopReq  = host_rd && (host_addr == REG_DATA);
    assign rxPushReq = host_wr && (host_addr == REG_DATA);
    assign ctrlWr    = host_wr && (host_addr == REG_CTRL);
    assign flush     = ctrlWr && host_wdata[CT_FLUSH];

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_txFifo (
        .clk     (clk),
        .rstb    (rstb),
        .push_i  (txEdge),
        .pop_i   (txPopReq),
        .flush_i (flush),
        .wdata_i (odt_tx_data),
        .head_o  (txHead),
        .full_o  (txFull),
        .count_o (txCount)
    );

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_rxFifo (
        .clk     (clk),
        .rstb    (rstb),
        .push_i  (rxPushReq),
        .pop_i   (rxEdge),
        .flush_i (flush),
        .wdata_i (host_wdata),
        .head_o  (rxHead),
        .full_o  (rxFull),
        .count_o (rxCount)
    );

    assign txNotEmpty = (txCount != '0);
    assign rxNotEmpty = (rxCount != '0);

`ifdef DLART_OVERRUN_EN
    logic ovr_q, ovr_d;
    logic txDrop, rxDrop;

    assign txDrop = txEdge && txFull && !(txPopReq && txNotEmpty) && !flush;
    assign rxDrop = rxPushReq && rxFull && !(rxEdge && rxNotEmpty) && !flush;

    // A drop in the same cycle as a clear keeps the flag set so no overrun is lost.
    always_comb begin
        ovr_d = ovr_q;
        if (ctrlWr && host_wdata[CT_CLROVR]) ovr_d = 1'b0;
        if (txDrop || rxDrop)                ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstb) ovr_q <= 1'b0;
        else       ovr_q <= ovr_d;
    end

    assign ovr = ovr_q;
    assign irq = txNotEmpty || ovr_q;
`else
    assign ovr = 1'b0;
    assign irq = txNotEmpty;
`endif

    assign odt_tx_rdy  = !txFull;
    assign odt_rx_rdy  = rxNotEmpty;
    assign odt_rx_data = rxHead;

    always_comb begin
        status                      = '0;
        status[ST_TXNE]             = txNotEmpty;
        status[ST_RXNF]             = !rxFull;
        status[ST_OVR]              = ovr;
        status[7:ST_CNT_LSB]        = 5'(txCount);
    end

    always_comb begin
        case (host_addr)
            REG_STATUS: host_rdata = status;
            REG_DATA:   host_rdata = txHead;
            default:    host_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_dlart_console_fifo.sv
// Self-checking bench for dlart_console_fifo: a per-cycle vector table followed by
// hand-written sequences for fill/overrun, full push+pop, flush and reset corners.
module tb_dlart_console_fifo;

`ifdef DLART_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstb;
    logic       odt_tx_stb;
    logic [7:0] odt_tx_data;
    logic       odt_tx_rdy;
    logic       odt_rx_stb;
    logic [7:0] odt_rx_data;
    logic       odt_rx_rdy;
    logic [1:0] host_addr;
    logic       host_rd;
    logic       host_wr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       irq;

    always #5 clk = ~clk;

    dlart_console_fifo #(.DEPTH_LOG2(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .odt_tx_stb  (odt_tx_stb),
        .odt_tx_data (odt_tx_data),
        .odt_tx_rdy  (odt_tx_rdy),
        .odt_rx_stb  (odt_rx_stb),
        .odt_rx_data (odt_rx_data),
        .odt_rx_rdy  (odt_rx_rdy),
        .host_addr   (host_addr),
        .host_rd     (host_rd),
        .host_wr     (host_wr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .irq         (irq)
    );

    typedef struct {
        logic       txStb;
        logic [7:0] txData;
        logic       rxStb;
        logic       rd;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [1:0] chkAddr;
        logic [7:0] expRdata;
        logic       expTxRdy;
        logic       expRxRdy;
        logic [7:0] expRxData;
        logic       expIrq;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    // Reference occupancy model for the hand-written sequences
    int         txCntM  = 0;
    int         rxCntM  = 0;
    bit         ovrM    = 1'b0;
    logic [7:0] rxHeadM = 8'h00;

    vec_t vecs [18];

    function automatic logic [7:0] statusOf(int tc, bit ov, int rc);
        logic [4:0] c;
        c = 5'(tc);
        return {c, ov, (rc < 16), (tc > 0)};
    endfunction

    function automatic vec_t modelVec(logic [1:0] chkA, logic [7:0] expData);
        vec_t v;
        v = '{default: '0};
        v.chkAddr   = chkA;
        v.expRdata  = (chkA == 2'd0) ? statusOf(txCntM, ovrM, rxCntM) : expData;
        v.expTxRdy  = (txCntM < 16);
        v.expRxRdy  = (rxCntM > 0);
        v.expRxData = (rxCntM > 0) ? rxHeadM : 8'h00;
        v.expIrq    = (txCntM > 0) || ovrM;
        return v;
    endfunction

    task automatic checkOne(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkOne({tag, " rdata"},   host_rdata,            v.expRdata);
        checkOne({tag, " tx_rdy"},  {7'd0, odt_tx_rdy},    {7'd0, v.expTxRdy});
        checkOne({tag, " rx_rdy"},  {7'd0, odt_rx_rdy},    {7'd0, v.expRxRdy});
        checkOne({tag, " rx_data"}, odt_rx_data,           v.expRxData);
        checkOne({tag, " irq"},     {7'd0, irq},           {7'd0, v.expIrq});
    endtask

    // One clock of stimulus, then outputs are checked mid-cycle with host_addr = chkAddr.
    task automatic applyStimulus(input string tag, input vec_t v);
        odt_tx_stb  = v.txStb;
        odt_tx_data = v.txData;
        odt_rx_stb  = v.rxStb;
        host_rd     = v.rd;
        host_wr     = v.wr;
        host_addr   = v.addr;
        host_wdata  = v.wdata;
        @(posedge clk);
        #1;
        host_rd   = 1'b0;
        host_wr   = 1'b0;
        host_addr = v.chkAddr;
        #1;
        checkOutput(tag, v);
    endtask

    task automatic stepM(input string tag, input logic txS, input logic [7:0] txD,
                         input logic rxS, input logic rd, input logic wr,
                         input logic [1:0] a, input logic [7:0] wd,
                         input logic [1:0] chkA, input logic [7:0] expData);
        vec_t v;
        v = modelVec(chkA, expData);
        v.txStb  = txS;
        v.txData = txD;
        v.rxStb  = rxS;
        v.rd     = rd;
        v.wr     = wr;
        v.addr   = a;
        v.wdata  = wd;
        applyStimulus(tag, v);
    endtask

    // Strobe high 4 clocks then low 2; the push lands on the 3rd clock.
    task automatic pulseTx(input string tag, input logic [7:0] d);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                if (txCntM < 16) txCntM++;
                else if (OVR_EN) ovrM = 1'b1;
            end
            stepM($sformatf("%s_k%0d", tag, k), (k < 4), d, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 8'h00);
        end
    endtask

    task automatic pulseRx(input string tag);
        for (int k = 0; k < 6; k++) begin
            if (k == 2 && rxCntM > 0) rxCntM--;
            stepM($sformatf("%s_k%0d", tag, k), 1'b0, 8'h00, (k < 4), 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 8'h00);
        end
    endtask

    initial begin
        #200us;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        //          txS txD    rxS rd wr addr wdata chk exp    txR rxR rxD    irq
        vecs[0]  = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[1]  = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[2]  = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[3]  = '{1, 8'h41, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[4]  = '{1, 8'h41, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[5]  = '{1, 8'h41, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h0B, 1, 0, 8'h00, 1};
        vecs[6]  = '{1, 8'h41, 0, 0, 0, 2'd0, 8'h00, 2'd1, 8'h41, 1, 0, 8'h00, 1};
        vecs[7]  = '{0, 8'h00, 0, 1, 0, 2'd1, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[8]  = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[9]  = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[10] = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[11] = '{0, 8'h00, 0, 0, 1, 2'd1, 8'h0D, 2'd0, 8'h02, 1, 1, 8'h0D, 0};
        vecs[12] = '{0, 8'h00, 1, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 1, 8'h0D, 0};
        vecs[13] = '{0, 8'h00, 1, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 1, 8'h0D, 0};
        vecs[14] = '{0, 8'h00, 1, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[15] = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h02, 1, 0, 8'h00, 0};
        vecs[16] = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd2, 8'h00, 1, 0, 8'h00, 0};
        vecs[17] = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd3, 8'h00, 1, 0, 8'h00, 0};

        rstb        = 1'b0;
        odt_tx_stb  = 1'b0;
        odt_tx_data = 8'h00;
        odt_rx_stb  = 1'b0;
        host_addr   = 2'd0;
        host_rd     = 1'b0;
        host_wr     = 1'b0;
        host_wdata  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", modelVec(2'd0, 8'h00));
        rstb = 1'b1;

        for (int i = 0; i < 18; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // Fill the tx FIFO past capacity: the 17th byte is dropped
        for (int i = 0; i < 17; i++)
            pulseTx($sformatf("fill%0d", i), 8'h60 + 8'(i));
        ovrM = 1'b0;
        stepM("clrovr", 0, 8'h00, 0, 0, 1, 2'd2, 8'h02, 2'd0, 8'h00);
        stepM("head60", 0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd1, 8'h60);

        // Full FIFO: strobe push and host pop on the same clock
        stepM("both0", 1, 8'h7A, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("both1", 1, 8'h7A, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("both2", 1, 8'h7A, 0, 1, 0, 2'd1, 8'h00, 2'd1, 8'h61);
        stepM("both3", 1, 8'h7A, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("both4", 0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("both5", 0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        for (int j = 0; j < 16; j++) begin
            logic [7:0] nextHead;
            nextHead = (j < 14) ? (8'h62 + 8'(j)) : ((j == 14) ? 8'h7A : 8'h00);
            txCntM--;
            stepM($sformatf("drain%0d", j), 0, 8'h00, 0, 1, 0, 2'd1, 8'h00, 2'd1, nextHead);
        end
        stepM("popEmpty", 0, 8'h00, 0, 1, 0, 2'd1, 8'h00, 2'd0, 8'h00);

        // Flush with 5 bytes in each FIFO, coincident with an rx pop edge
        for (int i = 0; i < 5; i++)
            pulseTx($sformatf("ftx%0d", i), 8'h20 + 8'(i));
        for (int i = 0; i < 5; i++) begin
            rxCntM++;
            if (i == 0) rxHeadM = 8'h30;
            stepM($sformatf("frx%0d", i), 0, 8'h00, 0, 0, 1, 2'd1, 8'h30 + 8'(i), 2'd0, 8'h00);
        end
        stepM("flush0", 0, 8'h00, 1, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("flush1", 0, 8'h00, 1, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        txCntM = 0;
        rxCntM = 0;
        stepM("flush2", 0, 8'h00, 1, 0, 1, 2'd2, 8'h01, 2'd0, 8'h00);
        stepM("flush3", 0, 8'h00, 1, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("flush4", 0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("flush5", 0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);

        // Rx pop while empty must not underflow the count
        pulseRx("rxEmptyPop");
        rxCntM  = 1;
        rxHeadM = 8'h55;
        stepM("rxWr55", 0, 8'h00, 0, 0, 1, 2'd1, 8'h55, 2'd0, 8'h00);
        pulseRx("rxPop55");

        // Reset mid-transfer with tx strobe held high through release
        pulseTx("preRst", 8'h99);
        odt_tx_stb  = 1'b1;
        odt_tx_data = 8'h99;
        rstb        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        txCntM = 0;
        rxCntM = 0;
        ovrM   = 1'b0;
        checkOutput("rstHi", modelVec(2'd0, 8'h00));
        rstb = 1'b1;
        for (int k = 0; k < 6; k++)
            stepM($sformatf("postRst%0d", k), 1, 8'h99, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("postRstLo0", 0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        stepM("postRstLo1", 0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd0, 8'h00);
        pulseTx("postRstPush", 8'h5A);
        stepM("head5A", 0, 8'h00, 0, 0, 0, 2'd0, 8'h00, 2'd1, 8'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dlart_console_fifo.md
Name: dlart_console_fifo

Overview:
- Console character buffer downstream of the DCJ11 bus interface's DLART emulation (XBUF/RBUF).
- Bus-interface side: strobe-driven transmit (CPU→host) and receive (host→CPU) byte paths.
- Host side: Apple II slot register window with a status register, a data register and a control register.
- Both directions are buffered by a synchronous FIFO, so ODT output bursts do not stall the CPU while the host is busy.

Parameters:
- DEPTH_LOG2, 4: log2 of each FIFO depth (16 entries).
- SYNC_STAGES, 2: synchroniser flops on the incoming odt strobes.

Ports:
- clk  in  1  system clock; all logic posedge.
- rstb  in  1  reset, synchronous, active-low.
- odt_tx_stb  in  1  async level strobe from the bus interface; rising edge = XBUF byte written.
- odt_tx_data  in  8  XBUF byte; stable while odt_tx_stb is high.
- odt_tx_rdy  out  1  tx FIFO not full; drives the bus interface's "ready to read" input.
- odt_rx_stb  in  1  async level strobe; rising edge = RBUF read by the CPU (pop).
- odt_rx_data  out  8  head of rx FIFO (show-ahead); 0 when empty.
- odt_rx_rdy  out  1  rx FIFO not empty; drives the bus interface's "ready to write" input (RCSR bit 7).
- host_addr  in  2  register select: 0 STATUS, 1 DATA, 2 CTRL, 3 reserved.
- host_rd  in  1  one-cycle read pulse.
- host_wr  in  1  one-cycle write pulse.
- host_wdata  in  8  write data.
- host_rdata  out  8  read data, combinational from host_addr.
- irq  out  1  high while tx FIFO not empty.

Behaviour:
- Reset (rstb=0 at posedge):
  - Both FIFOs are emptied and synchroniser/edge flops cleared.
  - Outputs after reset: odt_tx_rdy=1, odt_rx_rdy=0, odt_rx_data=0, irq=0, host_rdata per addr with empty FIFOs.
  - Reset mid-transfer discards buffered bytes. A strobe already high when reset releases produces no edge: edge flops reset to 0, and the synchroniser must settle high before any edge is seen.
- Strobe path:
  - Each odt strobe passes through SYNC_STAGES flops, then a rising-edge detector.
  - Push/pop happens at posedge SYNC_STAGES+1 after the strobe rises (cycle 3 by default).
  - odt_tx_data is sampled at the same posedge as the push. Upstream holds it for at least 4 clk.
  - Falling edges are ignored.
- Tx FIFO:
  - Pushed by the odt_tx_stb edge.
  - Popped by host_rd with addr 1, and only when not empty.
  - Push while full is dropped, unless a pop occurs in the same cycle; then both succeed.
- Rx FIFO:
  - Pushed by host_wr with addr 1.
  - Popped by the odt_rx_stb edge.
  - Push-while-full rule is the same as the tx FIFO.
  - Pop while empty is ignored, and the count stays 0.
- FIFO mechanics:
  - Pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1).
  - full = MSBs differ and the remaining bits are equal.
  - empty = pointers equal.
  - The count saturates at 2^DEPTH_LOG2 and never overflows.
- host_rdata:
  - addr 0 STATUS: {tx_count[4:0] clipped to bits 7:3, ovr, rx_not_full, tx_not_empty}, i.e. bit0 tx_not_empty, bit1 rx_not_full, bit2 ovr, bits7:3 tx_count.
  - addr 1 DATA: tx head, or 0 if empty.
  - addr 2: 0.
  - addr 3: 0.
- CTRL write (addr 2):
  - bit0=1 flushes both FIFOs at that posedge.
  - If a flush coincides with a strobe edge, the flush wins and the push is dropped.
  - bit1=1 clears ovr.
- Simultaneous host_rd and host_wr: both act; they affect different FIFOs when addr is 1.
- irq = tx_not_empty, registered from the FIFO state (no extra latency beyond the pointer update).

Optional Feature:
- DLART_OVERRUN_EN defined:
  - ovr is a sticky flag, set when any push is dropped due to full (either FIFO).
  - Cleared by CTRL bit1 or reset.
  - When ovr is set, irq = tx_not_empty | ovr.
- Not defined: ovr is constant 0, STATUS bit2 reads 0, CTRL bit1 is ignored, and there are no overrun flops.

Decomposition:
- dlart_pkg:
  - Register offsets REG_STATUS=2'd0, REG_DATA=2'd1, REG_CTRL=2'd2.
  - STATUS bit indices ST_TXNE=0, ST_RXNF=1, ST_OVR=2, ST_CNT_LSB=3.
  - CTRL bits CT_FLUSH=0, CT_CLROVR=1.
- Sub-module sync_fifo:
  - Parameters DEPTH_LOG2, width 8.
  - Show-ahead head, push/pop/flush, full/empty/count.
  - Instantiated twice, for tx and rx.

Test Plan:
- Reset then idle: odt_tx_rdy=1, odt_rx_rdy=0, STATUS=8'h02, irq=0.
- odt_tx_stb rise with data 8'h41, held 4 clk: push on 3rd posedge; STATUS=8'h0B, irq=1; host_rd addr1 returns 8'h41, then STATUS=8'h02.
- 17 tx strobes with no host reads: odt_tx_rdy=0 after 16th push; 17th byte dropped; tx_count=16, STATUS bits7:3=5'd16; with DLART_OVERRUN_EN, STATUS bit2=1 until CTRL write 8'h02.
- Host writes 8'h0D to addr1: odt_rx_rdy=1, odt_rx_data=8'h0D; odt_rx_stb rise pops it 3 clk later, and odt_rx_rdy returns to 0.
- Full tx FIFO with strobe edge and host_rd addr1 in the same cycle: count stays 16, the new byte is appended, and the head advances.
- CTRL write 8'h01 with 5 bytes in each FIFO and a coincident rx strobe edge: both FIFOs empty next cycle, odt_tx_rdy=1, odt_rx_rdy=0.
